// File: rtl/slave_ahb.sv
// slave_ahb: AHB word-memory slave with a fixed wait-state count and two-cycle ERROR responses.
// Only 32-bit aligned accesses that fall inside the memory window are serviced.
module slave_ahb #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned MEM_DEPTH   = 16,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        CLK_SLAVE,
    input  logic        RESET_SLAVE,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [1:0]  HTRANS,
    input  logic [31:0] HWDATA,
    output logic        HREADY,
    output logic        HRESP,
    output logic [31:0] HRDATA
);

    localparam int unsigned IdxW    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [32:0] EndAddr = {1'b0, BASE_ADDR} + 33'(MEM_DEPTH * 4);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DATA,
        S_ERR1,
        S_ERR2
    } state_e;

    state_e            state_q, state_d;
    logic [2:0]        wait_q, wait_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic              write_q, write_d;
    logic [2:0]        size_q, size_d;
    logic [31:0]       exp_addr_q, exp_addr_d;
    logic [31:0]       mem_q [MEM_DEPTH];

    logic              bus_ready;
    logic              accept;
    logic              xfer_err;
    logic [31:0]       offset;
    logic [31:0]       next_addr;

    // Bus is ready in every state except the stalled halves of wait and error phases.
    assign bus_ready = (state_q != S_WAIT) && (state_q != S_ERR1);
    assign accept    = bus_ready && HSEL && HTRANS[1];
    assign offset    = HADDR - BASE_ADDR;

    // Classify the presented address phase and compute where the next SEQ beat must land.
    always_comb begin
        xfer_err = 1'b0;
        if (HADDR < BASE_ADDR)                      xfer_err = 1'b1;
        if ({1'b0, HADDR} >= EndAddr)               xfer_err = 1'b1;
        if (HADDR[1:0] != 2'b00)                    xfer_err = 1'b1;
        if (HSIZE != 3'b010)                        xfer_err = 1'b1;
        if (HTRANS == 2'b11 && HADDR != exp_addr_q) xfer_err = 1'b1;

        // WRAP4 of words wraps inside the 16-byte block.
        if (HBURST == 3'b010) begin
            next_addr = {HADDR[31:4], HADDR[3:0] + 4'd4};
        end else begin
            next_addr = HADDR + 32'd4;
        end
    end

    // Next-state logic: address phases are only evaluated in bus-ready states.
    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        idx_d      = idx_q;
        write_d    = write_q;
        size_d     = size_q;
        exp_addr_d = exp_addr_q;

        case (state_q)
            S_WAIT: begin
                if (wait_q == 3'd0) begin
                    state_d = S_DATA;
                end else begin
                    wait_d = wait_q - 3'd1;
                end
            end
            S_ERR1: state_d = S_ERR2;
            default: begin
                // S_IDLE, S_DATA and S_ERR2 all complete this cycle and may take a new beat.
                if (accept) begin
                    idx_d      = IdxW'(offset >> 2);
                    write_d    = HWRITE;
                    size_d     = HSIZE;
                    exp_addr_d = next_addr;
                    if (xfer_err) begin
                        state_d = S_ERR1;
                    end else if (WAIT_STATES != 0) begin
                        state_d = S_WAIT;
                        wait_d  = 3'(WAIT_STATES - 1);
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge CLK_SLAVE or posedge RESET_SLAVE) begin
        if (RESET_SLAVE) begin
            state_q    <= S_IDLE;
            wait_q     <= 3'd0;
            idx_q      <= '0;
            write_q    <= 1'b0;
            size_q     <= 3'd0;
            exp_addr_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            idx_q      <= idx_d;
            write_q    <= write_d;
            size_q     <= size_d;
            exp_addr_q <= exp_addr_d;
        end
    end

    // Memory array: cleared by reset, written at the end of a write data phase.
    always_ff @(posedge CLK_SLAVE or posedge RESET_SLAVE) begin
        if (RESET_SLAVE) begin
            for (int i = 0; i < int'(MEM_DEPTH); i++) begin
                mem_q[i] <= 32'd0;
            end
        end else if (state_q == S_DATA && write_q && size_q == 3'b010) begin
            mem_q[idx_q] <= HWDATA;
        end
    end

    // Bus outputs decoded from the current state; read data only appears in a read data phase.
    always_comb begin
        HREADY = bus_ready;
        HRESP  = 1'b0;
        HRDATA = 32'd0;
        case (state_q)
            S_ERR1, S_ERR2: HRESP = 1'b1;
            S_DATA: begin
                if (!write_q) HRDATA = mem_q[idx_q];
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_slave_ahb.sv
// tb_slave_ahb: directed AHB traffic into a zero-wait and a two-wait slave_ahb, checked every
// cycle against a per-cycle expectation queue plus literal spot checks.
module tb_slave_ahb;

    logic CLK_MASTER = 1'b0;
    always #5 CLK_MASTER = ~CLK_MASTER;

    logic        rst = 1'b0;
    logic        hsel;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [1:0]  htrans;
    logic [31:0] hwdata;
    logic        sel = 1'b0;

    logic        hsel0, hsel1;
    logic        hready0, hresp0, hready1, hresp1;
    logic [31:0] hrdata0, hrdata1;
    logic        hr, hp;
    logic [31:0] hd;

    assign hsel0 = hsel & ~sel;
    assign hsel1 = hsel & sel;
    assign hr    = sel ? hready1 : hready0;
    assign hp    = sel ? hresp1  : hresp0;
    assign hd    = sel ? hrdata1 : hrdata0;

    slave_ahb #(.BASE_ADDR(32'h0), .MEM_DEPTH(16), .WAIT_STATES(0)) u_dut0 (
        .CLK_SLAVE(CLK_MASTER), .RESET_SLAVE(rst), .HSEL(hsel0), .HADDR(haddr),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HTRANS(htrans), .HWDATA(hwdata),
        .HREADY(hready0), .HRESP(hresp0), .HRDATA(hrdata0)
    );

    slave_ahb #(.BASE_ADDR(32'h0), .MEM_DEPTH(16), .WAIT_STATES(2)) u_dut1 (
        .CLK_SLAVE(CLK_MASTER), .RESET_SLAVE(rst), .HSEL(hsel1), .HADDR(haddr),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HTRANS(htrans), .HWDATA(hwdata),
        .HREADY(hready1), .HRESP(hresp1), .HRDATA(hrdata1)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: queue of expected bus cycles ----------------
    typedef struct {
        bit ready;
        bit resp;
        bit rd;
        bit wr;
        int idx;
    } cyc_t;

    function automatic cyc_t mk(bit ready, bit resp, bit rd, bit wr, int idx);
        cyc_t c;
        c.ready = ready; c.resp = resp; c.rd = rd; c.wr = wr; c.idx = idx;
        return c;
    endfunction

    cyc_t        exp_q[$];
    logic [31:0] mmem [2][16];
    logic [31:0] mexp [2];

    always @(posedge CLK_MASTER or posedge rst) begin : model
        cyc_t cur;
        bit   err;
        int   ws;
        if (rst) begin
            exp_q.delete();
            for (int s = 0; s < 2; s++) begin
                mexp[s] = 32'd0;
                for (int i = 0; i < 16; i++) mmem[s][i] = 32'd0;
            end
        end else begin
            if (exp_q.size() > 0) cur = exp_q.pop_front();
            else                  cur = mk(1, 0, 0, 0, 0);
            if (cur.wr) mmem[sel][cur.idx] = hwdata;
            if (cur.ready && hsel && htrans[1]) begin
                ws  = sel ? 2 : 0;
                err = (haddr >= 32'd64) || (haddr[1:0] != 2'b00) || (hsize != 3'b010) ||
                      (htrans == 2'b11 && haddr != mexp[sel]);
                if (hburst == 3'b010) mexp[sel] = (haddr & ~32'hF) | ((haddr + 32'd4) & 32'hF);
                else                  mexp[sel] = haddr + 32'd4;
                if (err) begin
                    exp_q.push_back(mk(0, 1, 0, 0, 0));
                    exp_q.push_back(mk(1, 1, 0, 0, 0));
                end else begin
                    for (int k = 0; k < ws; k++) exp_q.push_back(mk(0, 0, 0, 0, 0));
                    exp_q.push_back(mk(1, 0, !hwrite, hwrite, int'(haddr[5:2])));
                end
            end
        end
    end

    // Per-cycle comparison of the selected slave against the model.
    always @(negedge CLK_MASTER) begin : cmp
        cyc_t        e;
        logic [31:0] erd;
        if (exp_q.size() > 0) e = exp_q[0];
        else                  e = mk(1, 0, 0, 0, 0);
        erd = e.rd ? mmem[sel][e.idx] : 32'd0;
        check("cyc_hready", {31'd0, hr}, {31'd0, e.ready});
        check("cyc_hresp", {31'd0, hp}, {31'd0, e.resp});
        check("cyc_hrdata", hd, erd);
    end

    // ---------------- master tasks ----------------
    typedef struct {
        bit          hs;
        logic [1:0]  trans;
        logic [31:0] addr;
        bit          wr;
        logic [2:0]  size;
        logic [2:0]  burst;
        logic [31:0] wdata;
    } beat_t;

    beat_t bq[$];

    task automatic beat(input bit hs, input logic [1:0] tr, input logic [31:0] a, input bit w,
                        input logic [2:0] sz, input logic [2:0] bu, input logic [31:0] d);
        beat_t b;
        b.hs = hs; b.trans = tr; b.addr = a; b.wr = w; b.size = sz; b.burst = bu; b.wdata = d;
        bq.push_back(b);
    endtask

    task automatic drive_idle();
        hsel = 1'b0; htrans = 2'b00; haddr = 32'd0; hwrite = 1'b0;
        hsize = 3'b010; hburst = 3'b000;
    endtask

    // Wait for HREADY, then step past the edge that samples the current address phase.
    task automatic wait_accept(input string name);
        int n = 0;
        while (!hr && n < 64) begin
            @(negedge CLK_MASTER);
            n++;
        end
        if (n >= 64) begin
            checks++;
            failures++;
            $display("FAIL %s: HREADY stuck low for %0d cycles, required high", name, n);
        end
        @(negedge CLK_MASTER);
    endtask

    task automatic run_beats();
        logic [31:0] pend = 32'd0;
        foreach (bq[i]) begin
            hsel = bq[i].hs; htrans = bq[i].trans; haddr = bq[i].addr; hwrite = bq[i].wr;
            hsize = bq[i].size; hburst = bq[i].burst; hwdata = pend;
            wait_accept("beat_accept");
            pend = bq[i].wdata;
        end
        drive_idle();
        hwdata = pend;
        wait_accept("tail_accept");
        hwdata = 32'd0;
        bq.delete();
    endtask

    task automatic read_lit(input logic [31:0] a, input logic [31:0] exp, input int ws);
        int n = 0;
        hsel = 1'b1; htrans = 2'b10; haddr = a; hwrite = 1'b0; hsize = 3'b010; hburst = 3'b000;
        wait_accept("rd_accept");
        drive_idle();
        while (!hr && n < 16) begin
            @(negedge CLK_MASTER);
            n++;
        end
        check("rd_waits", n, ws);
        check("rd_data", hd, exp);
        check("rd_resp", {31'd0, hp}, 32'd0);
    endtask

    task automatic err_lit(input logic [31:0] a, input logic [2:0] sz);
        hsel = 1'b1; htrans = 2'b10; haddr = a; hwrite = 1'b1; hsize = sz; hburst = 3'b000;
        wait_accept("err_accept");
        drive_idle();
        hwdata = 32'hBAD0_BAD0;
        check("err1_hready", {31'd0, hr}, 32'd0);
        check("err1_hresp", {31'd0, hp}, 32'd1);
        @(negedge CLK_MASTER);
        check("err2_hready", {31'd0, hr}, 32'd1);
        check("err2_hresp", {31'd0, hp}, 32'd1);
        @(negedge CLK_MASTER);
        hwdata = 32'd0;
    endtask

    task automatic set_sel(input logic s);
        drive_idle();
        repeat (2) @(negedge CLK_MASTER);
        sel = s;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        drive_idle();
        hwdata = 32'd0;
        #1 rst = 1'b1;
        #2;
        check("rst_hready0", {31'd0, hready0}, 32'd1);
        check("rst_hresp0", {31'd0, hresp0}, 32'd0);
        check("rst_hrdata0", hrdata0, 32'd0);
        check("rst_hready1", {31'd0, hready1}, 32'd1);
        repeat (2) @(negedge CLK_MASTER);
        rst = 1'b0;
        @(negedge CLK_MASTER);

        // Zero-wait single write then read.
        beat(1, 2'b10, 32'h04, 1, 3'b010, 3'b000, 32'hA5A5_0001);
        run_beats();
        read_lit(32'h04, 32'hA5A5_0001, 0);

        // Two-wait INCR4 write and read-back.
        set_sel(1'b1);
        for (int i = 0; i < 4; i++)
            beat(1, (i == 0) ? 2'b10 : 2'b11, 32'h10 + 32'(4 * i), 1, 3'b010, 3'b011,
                 32'h1111_0000 + 32'(i));
        run_beats();
        for (int i = 0; i < 4; i++) read_lit(32'h10 + 32'(4 * i), 32'h1111_0000 + 32'(i), 2);
        beat(1, 2'b10, 32'h24, 1, 3'b010, 3'b000, 32'hCAFE_0024);
        beat(1, 2'b10, 32'h24, 0, 3'b010, 3'b000, 32'h0);
        run_beats();

        // WRAP4 write and read in order 38,3C,30,34, then a broken wrap through 0x40.
        set_sel(1'b0);
        for (int i = 0; i < 4; i++)
            beat(1, (i == 0) ? 2'b10 : 2'b11, 32'h30 + 32'((4 * (i + 2)) % 16), 1, 3'b010,
                 3'b010, 32'h5700_0000 + 32'(i));
        run_beats();
        for (int i = 0; i < 4; i++)
            beat(1, (i == 0) ? 2'b10 : 2'b11, 32'h30 + 32'((4 * (i + 2)) % 16), 0, 3'b010,
                 3'b010, 32'h0);
        run_beats();
        beat(1, 2'b10, 32'h38, 1, 3'b010, 3'b010, 32'hE000_0000);
        beat(1, 2'b11, 32'h3C, 1, 3'b010, 3'b010, 32'hE000_0001);
        beat(1, 2'b11, 32'h40, 1, 3'b010, 3'b010, 32'hE000_0002);
        beat(1, 2'b11, 32'h34, 1, 3'b010, 3'b010, 32'hE000_0003);
        run_beats();
        read_lit(32'h38, 32'hE000_0000, 0);
        read_lit(32'h3C, 32'hE000_0001, 0);
        read_lit(32'h30, 32'h5700_0002, 0);
        read_lit(32'h34, 32'h5700_0003, 0);

        // Out-of-range, unaligned and bad-size writes leave memory untouched.
        err_lit(32'h40, 3'b010);
        err_lit(32'h02, 3'b010);
        err_lit(32'h08, 3'b000);
        read_lit(32'h00, 32'h0, 0);
        read_lit(32'h08, 32'h0, 0);

        // Back-to-back write/read with IDLE, BUSY and deselected beats interleaved.
        beat(1, 2'b10, 32'h08, 1, 3'b010, 3'b000, 32'h0000_1234);
        beat(1, 2'b10, 32'h08, 0, 3'b010, 3'b000, 32'hFFFF_FFFF);
        beat(1, 2'b00, 32'h0C, 1, 3'b010, 3'b000, 32'hFFFF_0001);
        beat(1, 2'b01, 32'h0C, 1, 3'b010, 3'b001, 32'hFFFF_0002);
        beat(0, 2'b10, 32'h0C, 1, 3'b010, 3'b000, 32'hFFFF_0003);
        beat(1, 2'b10, 32'h0C, 0, 3'b010, 3'b000, 32'h0);
        beat(1, 2'b10, 32'h08, 0, 3'b010, 3'b000, 32'h0);
        run_beats();
        read_lit(32'h08, 32'h0000_1234, 0);
        read_lit(32'h0C, 32'h0, 0);

        // Reset pulsed while a write sits in its wait states.
        set_sel(1'b1);
        hsel = 1'b1; htrans = 2'b10; haddr = 32'h10; hwrite = 1'b1;
        hsize = 3'b010; hburst = 3'b000;
        wait_accept("rst_wr_accept");
        drive_idle();
        hwdata = 32'hDEAD_BEEF;
        check("pre_rst_hready", {31'd0, hr}, 32'd0);
        #2 rst = 1'b1;
        #1;
        check("async_rst_hready", {31'd0, hready1}, 32'd1);
        check("async_rst_hresp", {31'd0, hresp1}, 32'd0);
        check("async_rst_hrdata", hrdata1, 32'd0);
        @(negedge CLK_MASTER);
        rst = 1'b0;
        hwdata = 32'd0;
        read_lit(32'h10, 32'h0, 2);
        read_lit(32'h14, 32'h0, 2);

        drive_idle();
        repeat (2) @(negedge CLK_MASTER);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/slave_ahb.md
SLAVE_AHB -- requirements
Module: slave_ahb

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000: byte address of memory word 0.
REQ-002 Parameter MEM_DEPTH, default 16: number of 32-bit words; fixed power of two, at most 16.
REQ-003 Parameter WAIT_STATES, default 0: HREADY-low cycles inserted per OKAY data phase; range 0..7.
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset: CLK_SLAVE in 1, rising-edge clock; RESET_SLAVE in 1, reset.
REQ-005 HSEL in 1: slave select.
REQ-006 HADDR in 32: transfer address.
REQ-007 HWRITE in 1: 1 = write, 0 = read.
REQ-008 HSIZE in 3: transfer size; only 3'b010 is legal.
REQ-009 HBURST in 3: burst type; 000 = SINGLE, 001 = INCR, 010 = WRAP4, 011 = INCR4.
REQ-010 HTRANS in 2: transfer type; 00 = IDLE, 01 = BUSY, 10 = NONSEQ, 11 = SEQ.
REQ-011 HWDATA in 32: write data, valid in the data phase.
REQ-012 HREADY out 1: transfer done; also the bus-ready term the slave samples.
REQ-013 HRESP out 1: 0 = OKAY, 1 = ERROR.
REQ-014 HRDATA out 32: read data.

Function
REQ-015 Address phase SHALL be accepted on a rising edge with HREADY=1, HSEL=1, HTRANS in {NONSEQ, SEQ}; on acceptance, register address, HWRITE, HSIZE and HBURST.
REQ-016 IDLE, BUSY or HSEL=0 with HREADY=1 SHALL be accepted as a zero-wait OKAY: no memory access, no state change other than the FSM going to S_IDLE.
REQ-017 Word index SHALL be (HADDR - BASE_ADDR) >> 2, truncated to log2(MEM_DEPTH) bits.
REQ-018 An accepted transfer SHALL be an error when any of the following holds: HADDR < BASE_ADDR; HADDR >= BASE_ADDR + 4*MEM_DEPTH; HADDR[1:0] != 0; HSIZE != 3'b010; a SEQ beat address differs from the expected address (REQ-019).
REQ-019 Expected SEQ address SHALL be the previous beat address + 4 for INCR/INCR4; for WRAP4, the low 4 bits wrap within the 16-byte block (e.g. 0x0C -> 0x00). The expected address SHALL be updated on every accepted beat.
REQ-020 FSM states: S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2.
REQ-021 Transitions from S_IDLE and S_DATA:
- accepted OKAY transfer -> S_WAIT if WAIT_STATES > 0, else S_DATA
- accepted error transfer -> S_ERR1
- otherwise -> S_IDLE
REQ-022 S_WAIT SHALL hold HREADY=0, HRESP=0 for exactly WAIT_STATES cycles using a 3-bit down-counter, then go to S_DATA.
REQ-023 In S_DATA, HREADY=1 and HRESP=0. A write SHALL store HWDATA to mem[index] on the S_DATA clock edge. A read SHALL drive HRDATA = mem[index] combinationally during S_DATA.
REQ-024 A new address phase SHALL be acceptable in the same cycle as a completing S_DATA; back-to-back zero-wait beats sustain one word per cycle.
REQ-025 S_ERR1: HREADY=0, HRESP=1. S_ERR2: HREADY=1, HRESP=1, then re-evaluate per REQ-021. An error SHALL never modify memory; HRDATA SHALL be 0 during an error.
REQ-026 A read of a word written in the immediately preceding data phase SHALL return the new data.
REQ-027 HRDATA SHALL be 0 whenever the FSM is not in S_DATA with a read.
REQ-028 An address phase presented while HREADY=0 SHALL be ignored; the master must hold it, and it is re-sampled when HREADY=1.

Reset
REQ-029 Asserting RESET_SLAVE SHALL immediately, without a clock edge:
- set FSM to S_IDLE
- set HREADY=1, HRESP=0, HRDATA=0
- clear the wait counter and expected address
- clear all memory words to 0
REQ-030 Reset asserted mid-transfer (including S_WAIT and S_ERR1) SHALL abort the transfer with no memory write; after deassertion the first rising edge accepts a new transfer.

Verification
REQ-031 WAIT_STATES=0: NONSEQ SINGLE write 0xA5A5_0001 to 0x04, then read 0x04 -> HREADY stays 1; HRDATA = 0xA5A5_0001 in the read data phase.
REQ-032 WAIT_STATES=2: INCR4 write to 0x10..0x1C -> each beat shows 2 cycles HREADY=0 then 1 cycle HREADY=1; read-back returns all four words.
REQ-033 WRAP4 starting 0x38, beats 0x38, 0x3C, 0x30, 0x34 -> all OKAY; the same sequence with 0x40 as the third beat -> ERROR on that beat.
REQ-034 Write to 0x40 (out of range), write to 0x02 (unaligned), and HSIZE=000 -> each gives HRESP=1 for two cycles with HREADY 0 then 1; memory unchanged.
REQ-035 Back-to-back write 0x08 = 0x1234 then read 0x08 -> read returns 0x1234; IDLE and BUSY cycles interleaved -> zero-wait OKAY with no memory change.
REQ-036 RESET_SLAVE pulsed during S_WAIT of a write -> outputs go to reset values asynchronously; a subsequent read of that address returns 0.
